pio_mwr_requester: RTL and testbench

Bus-master posted-write initiator for the PCIe endpoint. It takes 32-bit user write requests, buffers them in a small FIFO, and emits 1-DW Memory Write TLPs on the core's 64-bit AXIS TX interface (s_axis_tx_*). It is the initiator-side counterpart of the PIO completer path. Its busy output lets the turn-off controller hold off cfg_turnoff_ok while writes are pending.

---
 rtl/pio_mwr_requester.sv | 244 ++++++++++++++++++++++++
 tb/tb_pio_mwr_requester.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_mwr_requester.sv
// Bus-master posted-write initiator: buffers user writes and emits 1-DW MWr TLPs on the 64-bit TX AXIS.
// Optional 4-DW header support for 64-bit addresses is enabled with `define PIO_MWR_4DW_EN.
module pio_mwr_requester #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int TCQ          = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    s_axis_aclk,
    input  logic                    rst_n,
    input  logic [15:0]             cfg_completer_id,
    input  logic                    cfg_bus_mstr_enable,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
`ifdef PIO_MWR_4DW_EN
    input  logic [31:0]             req_addr_hi,
`endif
    input  logic [31:0]             req_data,
    input  logic [3:0]              req_be,
    input  logic                    s_axis_tx_tready,
    output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
    output logic                    s_axis_tx_tlast,
    output logic                    s_axis_tx_tvalid,
    output logic                    tx_src_dsc,
    output logic                    busy,
    output logic [15:0]             sent_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [AW:0]   ptr_t;
    typedef logic [AW-1:0] idx_t;

`ifdef PIO_MWR_4DW_EN
    typedef enum logic [1:0] {IDLE, HDR, DATA, DATA2} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`endif

    generate
        if (C_DATA_WIDTH != 64 || KEEP_WIDTH != 8 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TCQ < 0) begin : g_bad_params
            $error("pio_mwr_requester: unsupported parameter set");
        end
    endgenerate

    function automatic logic [63:0] hdr_beat(input logic        long_hdr,
                                             input logic [15:0] id,
                                             input logic [7:0]  tag,
                                             input logic [3:0]  be);
        logic [31:0] dw0;
        dw0 = long_hdr ? 32'h6000_0001 : 32'h4000_0001;
        return {id, tag, 4'h0, be, dw0};
    endfunction

    function automatic logic [31:0] swap_bytes(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic [29:0] addr_mem [FIFO_DEPTH];
    logic [31:0] data_mem [FIFO_DEPTH];
    logic [3:0]  be_mem   [FIFO_DEPTH];
`ifdef PIO_MWR_4DW_EN
    logic [31:0] hi_mem   [FIFO_DEPTH];
`endif

    ptr_t wr_ptr, rd_ptr, fifo_count;
    idx_t head_idx, next_idx;
    logic fifo_empty, fifo_full, has_next;
    logic push, pop, done;

    state_t            state_q, state_nxt;
    logic              tvalid_q, tvalid_nxt;
    logic [63:0]       tdata_q, tdata_nxt;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_nxt;
    logic              tlast_q, tlast_nxt;
    logic [7:0]        tag_q;
    logic [15:0]       sent_q;

    logic [29:0] head_addr;
    logic [31:0] head_data;
    logic [3:0]  head_be, next_be;
    logic        head_long, next_long;
`ifdef PIO_MWR_4DW_EN
    logic [31:0] head_hi;
`endif

    // Address bits [1:0] are dropped because MWr addresses are DW aligned.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_count == ptr_t'(0));
    assign fifo_full  = (fifo_count == ptr_t'(FIFO_DEPTH));
    assign has_next   = (fifo_count > ptr_t'(1));
    assign req_ready  = rst_n & ~fifo_full;
    assign push       = req_valid & req_ready;

    assign head_idx  = rd_ptr[AW-1:0];
    assign next_idx  = head_idx + idx_t'(1);
    assign head_addr = addr_mem[head_idx];
    assign head_data = data_mem[head_idx];
    assign head_be   = be_mem[head_idx];
    assign next_be   = be_mem[next_idx];
`ifdef PIO_MWR_4DW_EN
    assign head_hi   = hi_mem[head_idx];
    assign head_long = (head_hi != 32'h0);
    assign next_long = (hi_mem[next_idx] != 32'h0);
`else
    assign head_long = 1'b0;
    assign next_long = 1'b0;
`endif

    always_ff @(posedge s_axis_aclk) begin
        if (push) begin
            addr_mem[wr_ptr[AW-1:0]] <= req_addr[31:2];
            data_mem[wr_ptr[AW-1:0]] <= req_data;
            be_mem[wr_ptr[AW-1:0]]   <= req_be;
`ifdef PIO_MWR_4DW_EN
            hi_mem[wr_ptr[AW-1:0]]   <= req_addr_hi;
`endif
        end
    end

    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    // Beats are registered one edge ahead so they hold while the core stalls.
    always_comb begin
        state_nxt  = state_q;
        tvalid_nxt = tvalid_q;
        tdata_nxt  = tdata_q;
        tkeep_nxt  = tkeep_q;
        tlast_nxt  = tlast_q;
        done       = 1'b0;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && cfg_bus_mstr_enable) begin
                    state_nxt  = HDR;
                    tvalid_nxt = 1'b1;
                    tdata_nxt  = hdr_beat(head_long, cfg_completer_id, tag_q, head_be);
                    tkeep_nxt  = 8'hFF;
                    tlast_nxt  = 1'b0;
                end
            end
            HDR: begin
                if (s_axis_tx_tready) begin
                    state_nxt = DATA;
                    tkeep_nxt = 8'hFF;
                    tdata_nxt = {swap_bytes(head_data), head_addr, 2'b00};
                    tlast_nxt = 1'b1;
`ifdef PIO_MWR_4DW_EN
                    if (head_long) begin
                        tdata_nxt = {head_addr, 2'b00, head_hi};
                        tlast_nxt = 1'b0;
                    end
`endif
                end
            end
            DATA: begin
                if (s_axis_tx_tready) begin
`ifdef PIO_MWR_4DW_EN
                    if (head_long) begin
                        state_nxt = DATA2;
                        tdata_nxt = {32'h0, swap_bytes(head_data)};
                        tkeep_nxt = 8'h0F;
                        tlast_nxt = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
`else
                    done = 1'b1;
`endif
                end
            end
`ifdef PIO_MWR_4DW_EN
            DATA2: begin
                if (s_axis_tx_tready) done = 1'b1;
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // Chain straight into the next header so back-to-back TLPs have no bubble.
        if (done) begin
            pop = 1'b1;
            if (has_next && cfg_bus_mstr_enable) begin
                state_nxt  = HDR;
                tvalid_nxt = 1'b1;
                tdata_nxt  = hdr_beat(next_long, cfg_completer_id, tag_q + 8'd1, next_be);
                tkeep_nxt  = 8'hFF;
                tlast_nxt  = 1'b0;
            end else begin
                state_nxt  = IDLE;
                tvalid_nxt = 1'b0;
                tdata_nxt  = '0;
                tkeep_nxt  = '0;
                tlast_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tag_q    <= '0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            tvalid_q <= tvalid_nxt;
            tdata_q  <= tdata_nxt;
            tkeep_q  <= tkeep_nxt;
            tlast_q  <= tlast_nxt;
            if (pop) begin
                tag_q  <= tag_q + 8'd1;
                sent_q <= sent_q + 16'd1;
            end
        end
    end

    assign s_axis_tx_tvalid = tvalid_q;
    assign s_axis_tx_tdata  = tdata_q;
    assign s_axis_tx_tkeep  = tkeep_q;
    assign s_axis_tx_tlast  = tlast_q;
    assign tx_src_dsc       = 1'b0;
    assign sent_count       = sent_q;
    assign busy             = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_pio_mwr_requester.sv
// Self-checking bench for pio_mwr_requester: directed scenarios plus a randomized run
// scored against a TLP-level reference model. Compile with PIO_MWR_4DW_EN to cover 4-DW headers.
module tb_pio_mwr_requester;

    logic        s_axis_aclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_completer_id = 16'h0100;
    logic        cfg_bus_mstr_enable = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_addr_hi = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_be = '0;
    logic        s_axis_tx_tready = 1'b0;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        tx_src_dsc;
    logic        busy;
    logic [15:0] sent_count;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] beat_log[$];
    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [7:0]  model_tag = '0;
    int          model_sent = 0;
    logic        stalled_prev = 1'b0;
    beat_t       stall_beat;
    logic        rand_mode = 1'b0;
    logic        accepted;

    always #5 s_axis_aclk = ~s_axis_aclk;

    pio_mwr_requester dut (
        .s_axis_aclk        (s_axis_aclk),
        .rst_n              (rst_n),
        .cfg_completer_id   (cfg_completer_id),
        .cfg_bus_mstr_enable(cfg_bus_mstr_enable),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_addr           (req_addr),
`ifdef PIO_MWR_4DW_EN
        .req_addr_hi        (req_addr_hi),
`endif
        .req_data           (req_data),
        .req_be             (req_be),
        .s_axis_tx_tready   (s_axis_tx_tready),
        .s_axis_tx_tdata    (s_axis_tx_tdata),
        .s_axis_tx_tkeep    (s_axis_tx_tkeep),
        .s_axis_tx_tlast    (s_axis_tx_tlast),
        .s_axis_tx_tvalid   (s_axis_tx_tvalid),
        .tx_src_dsc         (tx_src_dsc),
        .busy               (busy),
        .sent_count         (sent_count)
    );

    task automatic check_output(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic report_timeout(input string tag);
        n_compared++;
        n_mismatched++;
        $error("[TB] FAIL %s: bound expired, observed busy=%0b expected idle", tag, busy);
    endtask

    // Reference model: one accepted request becomes a list of expected wire beats.
    task automatic model_push(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input logic [31:0] hi);
        logic [31:0] dw0, dw1, a, sw;
        dw0 = (hi != 0) ? 32'h6000_0001 : 32'h4000_0001;
        dw1 = {cfg_completer_id, model_tag, 4'h0, be};
        a   = {addr[31:2], 2'b00};
        sw  = {data[7:0], data[15:8], data[23:16], data[31:24]};
        exp_q.push_back('{d: {dw1, dw0}, k: 8'hFF, l: 1'b0});
        if (hi != 0) begin
            exp_q.push_back('{d: {a, hi}, k: 8'hFF, l: 1'b0});
            exp_q.push_back('{d: {32'h0, sw}, k: 8'h0F, l: 1'b1});
        end else begin
            exp_q.push_back('{d: {sw, a}, k: 8'hFF, l: 1'b1});
        end
        model_tag = model_tag + 8'd1;
    endtask

    always @(negedge s_axis_aclk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check_output("hold_tvalid", s_axis_tx_tvalid, 1'b1);
                check_output("hold_beat", {s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast}, stall_beat);
            end
            if (s_axis_tx_tvalid && s_axis_tx_tready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_beat", s_axis_tx_tdata, 64'hx);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_output("beat", {s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast}, e);
                    if (e.l) model_sent++;
                end
                beat_log.push_back(s_axis_tx_tdata);
            end
            stalled_prev = s_axis_tx_tvalid && !s_axis_tx_tready;
            stall_beat   = {s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast};
            if (req_valid && req_ready) model_push(req_addr, req_data, req_be, req_addr_hi);
        end
    end

    always @(posedge s_axis_aclk) begin
        if (rand_mode) begin
            #1;
            s_axis_tx_tready    = ($urandom_range(0, 3) != 0);
            cfg_bus_mstr_enable = ($urandom_range(0, 7) != 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge s_axis_aclk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] be, input logic [31:0] hi);
        logic ok;
        ok = 1'b0;
        req_addr = addr; req_data = data; req_be = be; req_addr_hi = hi;
        req_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge s_axis_aclk);
            if (req_ready) ok = 1'b1;
            @(posedge s_axis_aclk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) report_timeout("push");
    endtask

    task automatic wait_idle(input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge s_axis_aclk);
            if (!busy && !s_axis_tx_tvalid && exp_q.size() == 0) ok = 1'b1;
        end
        @(posedge s_axis_aclk);
        #1;
        if (!ok) report_timeout("drain");
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values while rst_n is held low
        #22;
        check_output("rst_tvalid", s_axis_tx_tvalid, 1'b0);
        check_output("rst_tlast", s_axis_tx_tlast, 1'b0);
        check_output("rst_tdata", s_axis_tx_tdata, 64'h0);
        check_output("rst_tkeep", s_axis_tx_tkeep, 8'h0);
        check_output("rst_sent", sent_count, 16'h0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_ready", req_ready, 1'b0);
        check_output("src_dsc", tx_src_dsc, 1'b0);
        @(posedge s_axis_aclk); #1;
        rst_n = 1'b1;
        step(1);

        // Single write with latency check
        cfg_bus_mstr_enable = 1'b1;
        s_axis_tx_tready = 1'b1;
        beat_log.delete();
        apply_stimulus(32'h0000_1004, 32'h1122_3344, 4'hF, 32'h0);
        check_output("lat_e0_tvalid", s_axis_tx_tvalid, 1'b0);
        step(1);
        check_output("lat_e1_hdr", {s_axis_tx_tvalid, s_axis_tx_tlast}, 2'b10);
        step(1);
        check_output("lat_e2_data", {s_axis_tx_tvalid, s_axis_tx_tlast}, 2'b11);
        wait_idle(50);
        check_output("single_nbeats", beat_log.size(), 2);
        check_output("single_beat0", beat_log[0], 64'h0100_000F_4000_0001);
        check_output("single_beat1", beat_log[1], 64'h4433_2211_0000_1004);
        check_output("single_sent", sent_count, 16'd1);
        check_output("single_busy", busy, 1'b0);

        // Backpressure in HDR then DATA
        beat_log.delete();
        s_axis_tx_tready = 1'b0;
        apply_stimulus(32'hDEAD_BEE8, 32'hCAFE_F00D, 4'h3, 32'h0);
        step(6);
        check_output("bp_hdr_hold", {s_axis_tx_tvalid, s_axis_tx_tlast}, 2'b10);
        s_axis_tx_tready = 1'b1;
        step(1);
        s_axis_tx_tready = 1'b0;
        step(5);
        check_output("bp_data_hold", {s_axis_tx_tvalid, s_axis_tx_tlast}, 2'b11);
        check_output("bp_sent_mid", sent_count, 16'd1);
        s_axis_tx_tready = 1'b1;
        wait_idle(50);
        check_output("bp_sent", sent_count, 16'd2);
        check_output("bp_nbeats", beat_log.size(), 2);

        // Bus-master enable gating
        cfg_bus_mstr_enable = 1'b0;
        apply_stimulus(32'h0000_0100, 32'h0102_0304, 4'h0, 32'h0);
        apply_stimulus(32'h0000_0200, 32'hA5A5_5A5A, 4'hC, 32'h0);
        step(4);
        check_output("en_off_tvalid", s_axis_tx_tvalid, 1'b0);
        check_output("en_off_busy", busy, 1'b1);
        cfg_bus_mstr_enable = 1'b1;
        step(1);
        check_output("en_on_hdr", {s_axis_tx_tvalid, s_axis_tx_tlast}, 2'b10);
        step(1);
        check_output("en_on_data", {s_axis_tx_tvalid, s_axis_tx_tlast}, 2'b11);
        cfg_bus_mstr_enable = 1'b0;
        step(4);
        check_output("en_drop_tvalid", s_axis_tx_tvalid, 1'b0);
        check_output("en_drop_busy", busy, 1'b1);
        check_output("en_drop_sent", sent_count, 16'd3);
        cfg_bus_mstr_enable = 1'b1;
        wait_idle(50);
        check_output("en_sent", sent_count, 16'd4);

        // Reset in the middle of a stalled DATA beat
        s_axis_tx_tready = 1'b0;
        apply_stimulus(32'h1234_5678, 32'h8765_4321, 4'hF, 32'h0);
        step(1);
        s_axis_tx_tready = 1'b1;
        step(1);
        s_axis_tx_tready = 1'b0;
        step(2);
        check_output("mid_data", {s_axis_tx_tvalid, s_axis_tx_tlast}, 2'b11);
        @(negedge s_axis_aclk); #2;
        rst_n = 1'b0;
        stalled_prev = 1'b0;
        exp_q.delete();
        model_tag = '0;
        model_sent = 0;
        #1;
        check_output("arst_tvalid", s_axis_tx_tvalid, 1'b0);
        check_output("arst_busy", busy, 1'b0);
        check_output("arst_sent", sent_count, 16'd0);
        check_output("arst_ready", req_ready, 1'b0);
        repeat (2) @(posedge s_axis_aclk);
        #1;
        rst_n = 1'b1;
        step(1);

        // Fill the FIFO under backpressure, then drain without bubbles
        beat_log.delete();
        for (int i = 0; i < 4; i++) apply_stimulus(32'h0000_4000 + 32'(i * 16), $urandom, 4'hF, 32'h0);
        req_addr = 32'h0000_5000; req_data = 32'h5555_AAAA; req_be = 4'h1; req_valid = 1'b1;
        @(negedge s_axis_aclk);
        check_output("fill_full_ready", req_ready, 1'b0);
        @(posedge s_axis_aclk); #1;
        s_axis_tx_tready = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge s_axis_aclk);
            check_output("no_bubble", s_axis_tx_tvalid, 1'b1);
            if (req_valid && req_ready) accepted = 1'b1;
            @(posedge s_axis_aclk); #1;
            if (accepted) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check_output("fill_fifth_accepted", accepted, 1'b1);
        wait_idle(50);
        for (int i = 0; i < 4; i++) check_output("fill_tag", beat_log[2 * i][47:40], 8'(i));
        check_output("fill_sent", sent_count, 16'd5);

`ifdef PIO_MWR_4DW_EN
        // 4-DW header for a 64-bit address
        beat_log.delete();
        apply_stimulus(32'h8000_0000, 32'h0A0B_0C0D, 4'hF, 32'h1);
        wait_idle(50);
        check_output("4dw_nbeats", beat_log.size(), 3);
        check_output("4dw_dw0", beat_log[0][31:0], 32'h6000_0001);
        check_output("4dw_last_hi", beat_log[2][63:32], 32'h0);
        req_addr_hi = '0;
`endif

        // Randomized traffic against the reference model
        cfg_completer_id = 16'($urandom);
        rand_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
`ifdef PIO_MWR_4DW_EN
            apply_stimulus($urandom, $urandom, 4'($urandom_range(0, 15)),
                           ($urandom_range(0, 1) != 0) ? $urandom : 32'h0);
`else
            apply_stimulus($urandom, $urandom, 4'($urandom_range(0, 15)), 32'h0);
`endif
        end
        rand_mode = 1'b0;
        step(1);
        s_axis_tx_tready = 1'b1;
        cfg_bus_mstr_enable = 1'b1;
        wait_idle(500);
        check_output("rand_sent", sent_count, 16'(model_sent));
        check_output("rand_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
